// File: rtl/prince_ti_round_ctrl.sv
// prince_ti_round_ctrl
// Round sequencer for the 3-share round-based PRINCE TI core. Accepts a shared
// plaintext, steps the shared S-box pipeline through the 12 S-box layers
// (5 forward, 2 middle, 5 inverse), decodes the per-layer linear layer,
// round-constant index and key/whitening adds, stalls whenever fresh masks are
// missing, and holds the ciphertext until the consumer takes it.
module prince_ti_round_ctrl #(
   parameter int unsigned SBOX_STAGES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic       dec,
   output logic       in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   input  logic       rnd_valid,
   output logic       ld_en,
   output logic       st_en,
   output logic [2:0] stage_idx,
   output logic       layer_last,
   output logic       sbox_inv,
   output logic [1:0] lin_sel,
   output logic [3:0] rc_idx,
   output logic       key_add,
   output logic       whiten,
   output logic       dec_mode,
   output logic       busy
);

   // PRINCE always has 12 S-box layers, so the layer count is fixed.
   localparam int unsigned N_LAYERS   = 12;
   localparam logic [3:0]  LAYER_LAST = 4'(N_LAYERS - 1);
   localparam logic [3:0]  LAYER_MID  = 4'd5;
   localparam logic [2:0]  STAGE_LAST = 3'(SBOX_STAGES - 1);

   localparam logic [1:0]  LIN_NONE   = 2'b00;
   localparam logic [1:0]  LIN_M      = 2'b01;
   localparam logic [1:0]  LIN_MP     = 2'b10;
   localparam logic [1:0]  LIN_MINV   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   state_t     state_r;
   logic [3:0] layer_r;
   logic [2:0] stage_r;
   logic       in_ready_r;
   logic       out_valid_r;
   logic       busy_r;
   logic       dec_mode_r;
   logic       sbox_inv_r;

   logic       ld_en_s;
   logic       st_en_s;
   logic       layer_last_s;
   logic [1:0] lin_sel_s;
   logic [3:0] rc_idx_s;
   logic       key_add_s;
   logic       whiten_s;

   // Handshake-qualified strobes: load on acceptance, advance only when masks are fresh.
   always_comb begin
      ld_en_s      = 1'b0;
      st_en_s      = 1'b0;
      layer_last_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            ld_en_s = in_valid & in_ready_r;
         end
         ST_RUN: begin
            st_en_s = rnd_valid;
            if (stage_r == STAGE_LAST) begin
               layer_last_s = rnd_valid;
            end else begin
               layer_last_s = 1'b0;
            end
         end
         ST_OUT: begin
            ld_en_s      = 1'b0;
            st_en_s      = 1'b0;
            layer_last_s = 1'b0;
         end
         default: begin
            ld_en_s      = 1'b0;
            st_en_s      = 1'b0;
            layer_last_s = 1'b0;
         end
      endcase
   end

   // Per-layer control decode; all layer-end controls stay quiet outside layer_last.
   always_comb begin
      lin_sel_s = LIN_NONE;
      rc_idx_s  = 4'd0;
      key_add_s = 1'b0;
      whiten_s  = 1'b0;
      if (layer_last_s) begin
         case (layer_r)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
               lin_sel_s = LIN_M;
               rc_idx_s  = layer_r + 4'd1;
               key_add_s = 1'b1;
            end
            4'd5: begin
               lin_sel_s = LIN_MP;
               rc_idx_s  = 4'd0;
               key_add_s = 1'b0;
            end
            4'd6, 4'd7, 4'd8, 4'd9, 4'd10: begin
               lin_sel_s = LIN_MINV;
               rc_idx_s  = layer_r;
               key_add_s = 1'b1;
            end
            4'd11: begin
               lin_sel_s = LIN_NONE;
               rc_idx_s  = 4'd11;
               key_add_s = 1'b1;
               whiten_s  = 1'b1;
            end
            default: begin
               lin_sel_s = LIN_NONE;
               rc_idx_s  = 4'd0;
               key_add_s = 1'b0;
               whiten_s  = 1'b0;
            end
         endcase
      end else begin
         lin_sel_s = LIN_NONE;
         rc_idx_s  = 4'd0;
         key_add_s = 1'b0;
         whiten_s  = 1'b0;
      end
   end

   // Sequencer FSM with its stage/layer counters and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         layer_r     <= 4'd0;
         stage_r     <= 3'd0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         dec_mode_r  <= 1'b0;
         sbox_inv_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (ld_en_s) begin
                  state_r    <= ST_RUN;
                  layer_r    <= 4'd0;
                  stage_r    <= 3'd0;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  dec_mode_r <= dec;
                  sbox_inv_r <= 1'b0;
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            ST_RUN: begin
               if (st_en_s) begin
                  if (layer_last_s) begin
                     stage_r <= 3'd0;
                     if (layer_r == LAYER_LAST) begin
                        // Final layer done: leave RUN instead of wrapping the layer count.
                        state_r     <= ST_OUT;
                        out_valid_r <= 1'b1;
                        sbox_inv_r  <= 1'b0;
                     end else begin
                        layer_r <= layer_r + 4'd1;
                        if (layer_r == LAYER_MID) begin
                           sbox_inv_r <= 1'b1;
                        end else begin
                           sbox_inv_r <= sbox_inv_r;
                        end
                     end
                  end else begin
                     stage_r <= stage_r + 3'd1;
                  end
               end else begin
                  stage_r <= stage_r;
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  state_r     <= ST_IDLE;
                  layer_r     <= 4'd0;
                  out_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
                  in_ready_r  <= 1'b1;
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               layer_r     <= 4'd0;
               stage_r     <= 3'd0;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               sbox_inv_r  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready   = in_ready_r;
   assign out_valid  = out_valid_r;
   assign busy       = busy_r;
   assign dec_mode   = dec_mode_r;
   assign sbox_inv   = sbox_inv_r;
   assign stage_idx  = stage_r;
   assign ld_en      = ld_en_s;
   assign st_en      = st_en_s;
   assign layer_last = layer_last_s;
   assign lin_sel    = lin_sel_s;
   assign rc_idx     = rc_idx_s;
   assign key_add    = key_add_s;
   assign whiten     = whiten_s;

endmodule
